// File: rtl/ledr_ctrl_pkg.sv
// Shared definitions for the LED output controller: register map and
// fixed bit positions used by the bus read path.
package ledr_ctrl_pkg;

  typedef enum logic [2:0] {
    REG_DATA       = 3'd0,
    REG_SET        = 3'd1,
    REG_CLR        = 3'd2,
    REG_TGL        = 3'd3,
    REG_BLINK_MASK = 3'd4,
    REG_BLINK_DIV  = 3'd5,
    REG_STATUS     = 3'd6,
    REG_DUTY       = 3'd7
  } ledr_reg_e;

  localparam int STATUS_PHASE_BIT = 31;

  localparam logic [7:0] DUTY_FULL = 8'hFF;

endpackage

// File: rtl/ledr_blink_prescaler.sv
// Blink prescaler: counts 0..div and toggles the blink phase each time the
// terminal count is reached. A clear restarts the period with phase low so
// a new divider value always begins from a known point.
module ledr_blink_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             phase
);

  logic [DIV_W-1:0] count;

  // Count up to div, then wrap and flip the phase; clear wins over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      phase <= 1'b0;
    end else if (clear) begin
      count <= '0;
      phase <= 1'b0;
    end else if (count == div) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ledr_ctrl_peripheral.sv
// Memory-mapped LED controller: DATA register with atomic SET/CLR/TGL
// aliases, per-LED hardware blink and a registered LED drive.
// Optional 8-bit PWM dimming is built only when LEDR_PWM_EN is defined;
// otherwise the DUTY address reads 0 and ignores writes.
module ledr_ctrl_peripheral
  import ledr_ctrl_pkg::*;
#(
  parameter int               NUM_LEDS  = 10,
  parameter int               DIV_W     = 24,
  parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(4_999_999)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] ledr_output
);

  ledr_reg_e           reg_sel;
  logic [NUM_LEDS-1:0] data;
  logic [NUM_LEDS-1:0] blink_mask;
  logic [DIV_W-1:0]    blink_div;
  logic [NUM_LEDS-1:0] wd_leds;
  logic [DIV_W-1:0]    wd_div;
  logic [NUM_LEDS-1:0] lit_raw;
  logic [31:0]         read_value;
  logic                phase;
  logic                div_write;
  logic                pwm_gate;
  logic                unused_writedata;

  assign reg_sel          = ledr_reg_e'(address);
  assign wd_leds          = writedata[NUM_LEDS-1:0];
  assign wd_div           = writedata[DIV_W-1:0];
  assign div_write        = write && (reg_sel == REG_BLINK_DIV);
  assign unused_writedata = ^writedata;

  ledr_blink_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (div_write),
    .div   (blink_div),
    .phase (phase)
  );

  // Register bank writes; read-only and unmapped targets fall through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      blink_mask <= '0;
      blink_div  <= DIV_RESET;
    end else if (write) begin
      case (reg_sel)
        REG_DATA:       data       <= wd_leds;
        REG_SET:        data       <= data | wd_leds;
        REG_CLR:        data       <= data & ~wd_leds;
        REG_TGL:        data       <= data ^ wd_leds;
        REG_BLINK_MASK: blink_mask <= wd_leds;
        REG_BLINK_DIV:  blink_div  <= wd_div;
        default:        ;
      endcase
    end
  end

`ifdef LEDR_PWM_EN
  logic [7:0] duty;
  logic [7:0] pwm_cnt;

  // Free-running PWM counter, wraps 255 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Duty register; resets to full brightness so LEDs behave as undimmed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= DUTY_FULL;
    end else if (write && (reg_sel == REG_DUTY)) begin
      duty <= writedata[7:0];
    end
  end

  assign pwm_gate = (duty == DUTY_FULL) | (pwm_cnt < duty);
`else
  assign pwm_gate = 1'b1;
`endif

  // Read mux: every field zero-extended to 32 bits, write-only aliases read 0.
  always_comb begin
    read_value = '0;
    case (reg_sel)
      REG_DATA:       read_value[NUM_LEDS-1:0] = data;
      REG_BLINK_MASK: read_value[NUM_LEDS-1:0] = blink_mask;
      REG_BLINK_DIV:  read_value[DIV_W-1:0]    = blink_div;
      REG_STATUS: begin
        read_value[NUM_LEDS-1:0]     = ledr_output;
        read_value[STATUS_PHASE_BIT] = phase;
      end
`ifdef LEDR_PWM_EN
      REG_DUTY:       read_value[7:0]          = duty;
`endif
      default:        ;
    endcase
  end

  // Registered read data; sampled before any same-cycle write lands, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= read_value;
    end
  end

  assign lit_raw = data & (~blink_mask | {NUM_LEDS{phase}});

  // Registered LED drive combining raw state, blink phase and PWM gate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ledr_output <= '0;
    end else begin
      ledr_output <= lit_raw & {NUM_LEDS{pwm_gate}};
    end
  end

endmodule

// File: tb/tb_ledr_ctrl_peripheral.sv
// Testbench for ledr_ctrl_peripheral: directed bus transactions; read
// responses are checked by a scoreboard monitor, LED drive checked directly.
module tb_ledr_ctrl_peripheral;

  localparam int NUM_LEDS = 10;
  localparam logic [2:0] A_DATA = 3'd0, A_SET = 3'd1, A_CLR = 3'd2, A_TGL = 3'd3;
  localparam logic [2:0] A_MASK = 3'd4, A_DIV = 3'd5, A_STATUS = 3'd6, A_DUTY = 3'd7;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                write = 1'b0;
  logic                read = 1'b0;
  logic [2:0]          address = 3'd0;
  logic [31:0]         writedata = 32'd0;
  logic [31:0]         readdata;
  logic [NUM_LEDS-1:0] ledr_output;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen;

  ledr_ctrl_peripheral #(
    .NUM_LEDS  (NUM_LEDS),
    .DIV_W     (24),
    .DIV_RESET (24'd4_999_999)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .ledr_output (ledr_output)
  );

  always #5 clk = ~clk;

  // Remember which cycles issued a read so the monitor knows when data is due.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= read;
  end

  // Scoreboard monitor: compare each read response with the oldest expectation.
  always @(negedge clk) begin
    if (rd_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_read got=%h expected=none", readdata);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (readdata !== e) begin
          errors++;
          $display("[TB] FAIL %s got=%h expected=%h", n, readdata, e);
        end
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic rd, input logic [2:0] addr,
                               input logic [31:0] wd, input logic [31:0] exp, input string name);
    @(negedge clk);
    write     = wr;
    read      = rd;
    address   = addr;
    writedata = wd;
    if (rd) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clk);
    #1;
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic doWrite(input logic [2:0] addr, input logic [31:0] wd);
    applyStimulus(1'b1, 1'b0, addr, wd, 32'd0, "");
  endtask

  task automatic doRead(input logic [2:0] addr, input logic [31:0] exp, input string name);
    applyStimulus(1'b0, 1'b1, addr, 32'd0, exp, name);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic ph4(input int m);
    return (m >= 0) && (((m / 4) % 2) == 1);
  endfunction

  task automatic countLit(input string name, input int exp);
    int lit;
    lit = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      if (ledr_output[0]) lit++;
    end
    checkOutput(name, 32'(lit), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NUM_LEDS-1:0] exp_led;
    logic [31:0]         exp_word;
    logic [31:0]         div0_exp [4];

    // T1: asynchronous reset, no clock edge involved.
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_led", 32'(ledr_output), 32'd0);
    checkOutput("rst_rdata", readdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    doRead(A_DIV, 32'h004C_4B3F, "rst_div");
    doRead(A_MASK, 32'd0, "rst_mask");

    // Mid-cycle reset with LEDs lit and readdata nonzero.
    doWrite(A_DATA, 32'h3FF);
    doRead(A_DATA, 32'h3FF, "pre_rst_data");
    checkOutput("pre_rst_led", 32'(ledr_output), 32'h3FF);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_led", 32'(ledr_output), 32'd0);
    checkOutput("midrst_rdata", readdata, 32'd0);
    #1 rst = 1'b0;
    doRead(A_DATA, 32'd0, "post_rst_data");
    doRead(A_DIV, 32'h004C_4B3F, "post_rst_div");

    // T2: atomic updates.
    doWrite(A_DATA, 32'h0F0);
    doWrite(A_SET, 32'h001);
    doWrite(A_CLR, 32'h010);
    doWrite(A_TGL, 32'h300);
    checkOutput("t2_led_lag", 32'(ledr_output), 32'h0E1);
    idle(1);
    checkOutput("t2_led", 32'(ledr_output), 32'h3E1);
    doRead(A_DATA, 32'h3E1, "t2_data");
    doRead(A_SET, 32'd0, "t2_set_reads0");
    doRead(A_CLR, 32'd0, "t2_clr_reads0");
    doRead(A_TGL, 32'd0, "t2_tgl_reads0");

    // T3: blink on bits 0 and 2 with a 4-cycle half-period.
    doWrite(A_DATA, 32'h3FF);
    doWrite(A_MASK, 32'h005);
    doWrite(A_DIV, 32'd3);
    for (int n = 1; n <= 12; n++) begin
      exp_led  = (n >= 2 && ph4(n - 2)) ? 10'h3FF : 10'h3FA;
      exp_word = {ph4(n - 1), 21'd0, exp_led};
      doRead(A_STATUS, exp_word, $sformatf("t3_status_%0d", n));
      checkOutput($sformatf("t3_led_%0d", n), 32'(ledr_output),
                  ph4(n - 1) ? 32'h3FF : 32'h3FA);
    end

    // T4: divider rewrite while prescaler=2 and phase=1.
    idle(2);
    checkOutput("t4_pre_led", 32'(ledr_output), 32'h3FF);
    doWrite(A_DIV, 32'd9);
    for (int n = 1; n <= 12; n++) begin
      exp_led  = (n == 1 || n >= 12) ? 10'h3FF : 10'h3FA;
      exp_word = {(n >= 11) ? 1'b1 : 1'b0, 21'd0, exp_led};
      doRead(A_STATUS, exp_word, $sformatf("t4_status_%0d", n));
    end
    doWrite(A_MASK, 32'd0);

    // T5: read/write collision and ignored writes.
    doWrite(A_DATA, 32'h2AA);
    applyStimulus(1'b1, 1'b1, A_DATA, 32'h155, 32'h2AA, "t5_collide");
    doRead(A_DATA, 32'h155, "t5_after");
    doWrite(A_STATUS, 32'hFFFF_FFFF);
    doRead(A_DATA, 32'h155, "t5_status_wr");
    doWrite(A_SET, 32'hFFFF_FC00);
    doRead(A_DATA, 32'h155, "t5_high_bits");
    doRead(A_DIV, 32'd9, "t5_div");
    idle(1);
    checkOutput("t5_led", 32'(ledr_output), 32'h155);

    // BLINK_DIV=0: phase toggles every cycle.
    div0_exp[0] = 32'h8000_0155;
    div0_exp[1] = 32'h0000_0155;
    div0_exp[2] = 32'h8000_0154;
    div0_exp[3] = 32'h0000_0155;
    doWrite(A_DIV, 32'd0);
    doWrite(A_MASK, 32'h001);
    for (int n = 0; n < 4; n++) begin
      doRead(A_STATUS, div0_exp[n], $sformatf("div0_status_%0d", n));
    end
    doWrite(A_MASK, 32'd0);

`ifdef LEDR_PWM_EN
    // T6: PWM dimming.
    doRead(A_DUTY, 32'h0FF, "t6_duty_reset");
    doWrite(A_DATA, 32'h001);
    doWrite(A_DUTY, 32'd64);
    doRead(A_DUTY, 32'd64, "t6_duty_rb");
    idle(1);
    countLit("t6_duty64", 64);
    doWrite(A_DUTY, 32'd0);
    idle(1);
    countLit("t6_duty0", 0);
    doWrite(A_DUTY, 32'hFF);
    idle(1);
    countLit("t6_dutyff", 256);
`else
    // Without PWM: DUTY address is inert and LEDs are undimmed.
    doRead(A_DUTY, 32'd0, "t6_duty_absent");
    doWrite(A_DUTY, 32'h40);
    doRead(A_DUTY, 32'd0, "t6_duty_wr_ignored");
    doWrite(A_DATA, 32'h001);
    idle(1);
    countLit("t6_no_pwm", 256);
`endif

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
